i2c_burst_mem: RTL and testbench
================================

I2C_BURST_MEM -- requirements
Module: i2c_burst_mem

Interface
REQ-001 Parameter DATA_W, default 8, sets the data byte width in bits.
REQ-002 Parameter ADDR_W, default 7, sets the address width; DEPTH = 2**ADDR_W words.
REQ-003 clk  input  1  single clock for all state; every register samples on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high; asserting it immediately forces every register to its reset value.
REQ-005 start  input  1  one-cycle pulse from the I2C front end marking START or repeated START.
REQ-006 stop  input  1  one-cycle pulse marking STOP.
REQ-007 rw  input  1  transfer direction, sampled only when start=1; 0 = write, 1 = read.
REQ-008 rx_valid  input  1  one-cycle pulse: rx_data holds a received byte.
REQ-009 rx_data  input  DATA_W  received byte.
REQ-010 tx_req  input  1  one-cycle pulse: the front end requests the next read byte.
REQ-011 wp  input  1  write-protect level; when high, no memory write may occur.
REQ-012 tx_valid  output  1  one-cycle pulse: tx_data is valid.
REQ-013 tx_data  output  DATA_W  registered read byte.
REQ-014 ack  output  1  registered acknowledge for the last rx byte; 1 = ACK, 0 = NACK.
REQ-015 ptr  output  ADDR_W  current address pointer.
REQ-016 busy  output  1  high whenever the state is not IDLE.

Function
REQ-017 The state machine SHALL have four states: IDLE, ADDR, WRITE and READ.
REQ-018 start with rw=0 SHALL move the FSM from any state to ADDR on the next edge.
REQ-019 start with rw=1 SHALL move the FSM from any state to READ on the next edge; ptr is unchanged.
REQ-020 stop SHALL move the FSM from any state to IDLE; ptr and memory contents are retained.
REQ-021 If start and stop are asserted in the same cycle, start SHALL take priority.
REQ-022 Any rx_valid or tx_req in a cycle where start or stop is high SHALL be ignored.
REQ-023 In ADDR, rx_valid SHALL load ptr with rx_data[ADDR_W-1:0], set ack=1 and move the FSM to WRITE; upper bits beyond ADDR_W are discarded.
REQ-024 In WRITE with wp=0, rx_valid SHALL write rx_data to mem[ptr], increment ptr and set ack=1.
REQ-025 In WRITE with wp=1, rx_valid SHALL leave memory unchanged, still increment ptr and set ack=0.
REQ-026 In READ, tx_req SHALL drive tx_data=mem[ptr] with tx_valid=1 exactly one cycle later, and increment ptr.
REQ-027 ptr increments SHALL wrap modulo DEPTH (DEPTH-1 -> 0).
REQ-028 rx_valid in IDLE or READ SHALL be ignored; ack holds its value.
REQ-029 tx_req in IDLE, ADDR or WRITE SHALL be ignored; tx_valid stays 0.
REQ-030 A memory write and a tx read of the same address in the same cycle cannot occur, because WRITE and READ are exclusive states.
REQ-031 tx_data SHALL hold its last value when tx_valid=0.

Reset
REQ-032 While reset=1, all DEPTH words SHALL read as 0 and the FSM SHALL be in IDLE.
REQ-033 While reset=1, outputs SHALL be: ptr=0, tx_data=0, tx_valid=0, ack=0, busy=0.
REQ-034 Reset asserted mid-transaction SHALL abort the transaction with no partial write; after release the block waits in IDLE for start.

Verification
REQ-035 Burst write: reset; start(rw=0), rx 0x10, 0xA1, 0xB2, stop -> mem[0x10]=0xA1, mem[0x11]=0xB2, ptr=0x12, ack=1 each byte.
REQ-036 Random read: after REQ-035, start(rw=0), rx 0x10, start(rw=1), two tx_req -> tx_data 0xA1 then 0xB2, each one cycle after its tx_req; ptr=0x12.
REQ-037 Wrap: start(rw=0), rx 0x7F, 0x11, 0x22 -> mem[0x7F]=0x11, mem[0x00]=0x22, ptr=0x01.
REQ-038 Write protect: wp=1, start(rw=0), rx 0x05, 0x55 -> address byte ack=1, data byte ack=0, mem[0x05] unchanged, ptr=0x06.
REQ-039 Priority and reset: start and stop in the same cycle -> FSM enters ADDR/READ per rw. Reset pulse during WRITE -> busy=0, ptr=0, all reads return 0x00.

Source files
------------

// File: rtl/i2c_burst_mem.sv
// Byte-addressed register memory behind an I2C slave front end: an address byte
// followed by burst writes, or burst reads from the current pointer.
module i2c_burst_mem #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 7
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              rw,
    input  logic              rx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              tx_req,
    input  logic              wp,
    output logic              tx_valid,
    output logic [DATA_W-1:0] tx_data,
    output logic              ack,
    output logic [ADDR_W-1:0] ptr,
    output logic              busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [1:0] {IDLE, ADDR, WRITE, READ} state_t;

    state_t            state;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              bus_ctrl;
    logic              rx_ev;
    logic              tx_ev;
    logic              wr_en;

    // Bus conditions pre-empt byte events in the same cycle.
    assign bus_ctrl = start | stop;
    assign rx_ev    = rx_valid & ~bus_ctrl;
    assign tx_ev    = tx_req & ~bus_ctrl;
    assign wr_en    = (state == WRITE) & rx_ev & ~wp;

    // Flop-based storage so that reset clears every word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (wr_en) begin
            mem[ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            ptr      <= '0;
            ack      <= 1'b0;
            tx_valid <= 1'b0;
            tx_data  <= '0;
            busy     <= 1'b0;
        end else begin
            tx_valid <= 1'b0;
            if (start) begin
                state <= rw ? READ : ADDR;
                busy  <= 1'b1;
            end else if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else begin
                case (state)
                    ADDR: if (rx_ev) begin
                        ptr   <= rx_data[ADDR_W-1:0];
                        ack   <= 1'b1;
                        state <= WRITE;
                    end
                    WRITE: if (rx_ev) begin
                        ptr <= ptr + ADDR_W'(1);
                        ack <= ~wp;
                    end
                    READ: if (tx_ev) begin
                        tx_data  <= mem[ptr];
                        tx_valid <= 1'b1;
                        ptr      <= ptr + ADDR_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_i2c_burst_mem.sv
// Directed bench for i2c_burst_mem: burst write/read, wrap, write protect,
// start/stop priority and mid-transaction reset.
module tb_i2c_burst_mem;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0, stop = 1'b0, rw = 1'b0;
    logic       rx_valid = 1'b0, tx_req = 1'b0, wp = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       tx_valid, ack, busy;
    logic [7:0] tx_data;
    logic [6:0] ptr;

    int errors = 0;
    int checks = 0;
    logic [7:0] d;
    logic       v;

    i2c_burst_mem #(.DATA_W(8), .ADDR_W(7)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .rw(rw),
        .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .wp(wp),
        .tx_valid(tx_valid), .tx_data(tx_data), .ack(ack), .ptr(ptr), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic r);
        start = 1'b1; rw = r;
        cyc();
        start = 1'b0;
    endtask

    task automatic do_stop();
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1; rx_data = b;
        cyc();
        rx_valid = 1'b0;
    endtask

    task automatic rd(output logic [7:0] dd, output logic vv);
        tx_req = 1'b1;
        cyc();
        tx_req = 1'b0;
        vv = tx_valid;
        dd = tx_data;
    endtask

    // Random read of one address through a full bus transaction.
    task automatic rd_at(input logic [6:0] a, output logic [7:0] dd, output logic vv);
        do_start(1'b0);
        send({1'b0, a});
        do_start(1'b1);
        rd(dd, vv);
        do_stop();
    endtask

    initial begin
        // Reset state
        cyc(); cyc();
        chk("rst_ptr", ptr, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ack", ack, 0);
        chk("rst_txv", tx_valid, 0);
        chk("rst_txd", tx_data, 0);
        reset = 1'b0;
        cyc();

        // Burst write
        do_start(1'b0);
        chk("bw_busy", busy, 1);
        send(8'h10); chk("bw_ack_a", ack, 1); chk("bw_ptr_a", ptr, 7'h10);
        send(8'hA1); chk("bw_ack_1", ack, 1);
        send(8'hB2); chk("bw_ack_2", ack, 1);
        do_stop();
        chk("bw_ptr", ptr, 7'h12);
        chk("bw_idle", busy, 0);

        // Random read with repeated start
        do_start(1'b0);
        send(8'h10);
        do_start(1'b1);
        chk("rr_ptr_keep", ptr, 7'h10);
        rd(d, v);
        chk("rr_v1", v, 1); chk("rr_d1", d, 8'hA1);
        cyc();
        chk("rr_pulse", tx_valid, 0); chk("rr_hold", tx_data, 8'hA1);
        rd(d, v);
        chk("rr_v2", v, 1); chk("rr_d2", d, 8'hB2);
        chk("rr_ptr", ptr, 7'h12);
        do_stop();

        // tx_req while writing is ignored
        do_start(1'b0);
        send(8'h20);
        rd(d, v);
        chk("txreq_wr", v, 0);
        chk("txreq_wr_ptr", ptr, 7'h20);
        // rx_valid alongside stop is ignored
        stop = 1'b1; rx_valid = 1'b1; rx_data = 8'h77;
        cyc();
        stop = 1'b0; rx_valid = 1'b0;
        chk("rx_stop_ptr", ptr, 7'h20);
        rd_at(7'h20, d, v);
        chk("rx_stop_mem", d, 8'h00);

        // Wrap at top of memory
        do_start(1'b0);
        send(8'h7F); send(8'h11); send(8'h22);
        chk("wrap_ptr", ptr, 7'h01);
        do_start(1'b1);
        chk("wrap_rd_busy", busy, 1);
        do_stop();
        do_start(1'b0); send(8'h7F); do_start(1'b1);
        rd(d, v); chk("wrap_m7f", d, 8'h11);
        rd(d, v); chk("wrap_m00", d, 8'h22);
        chk("wrap_rptr", ptr, 7'h01);
        do_stop();

        // Write protect (pre-load 0x05, upper address bit discarded)
        do_start(1'b0); send(8'h05); send(8'h3C); do_stop();
        wp = 1'b1;
        do_start(1'b0);
        send(8'h85); chk("wp_ack_a", ack, 1); chk("wp_ptr_a", ptr, 7'h05);
        send(8'h55); chk("wp_ack_d", ack, 0); chk("wp_ptr", ptr, 7'h06);
        // rx in READ ignored: ack and ptr hold
        do_start(1'b1);
        send(8'h99); chk("rx_rd_ack", ack, 0); chk("rx_rd_ptr", ptr, 7'h06);
        do_stop();
        wp = 1'b0;
        rd_at(7'h05, d, v);
        chk("wp_mem", d, 8'h3C);

        // tx_req in IDLE ignored
        rd(d, v);
        chk("txreq_idle", v, 0);

        // start + stop together: start wins
        start = 1'b1; stop = 1'b1; rw = 1'b0;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("pri_w_busy", busy, 1);
        send(8'h30); chk("pri_w_addr", ptr, 7'h30);
        start = 1'b1; stop = 1'b1; rw = 1'b1;
        cyc();
        start = 1'b0; stop = 1'b0;
        chk("pri_r_ptr", ptr, 7'h30);
        rd(d, v); chk("pri_r_v", v, 1); chk("pri_r_ptr2", ptr, 7'h31);
        do_stop();

        // Reset during WRITE, with a data byte in flight
        do_start(1'b0);
        send(8'h40);
        rx_valid = 1'b1; rx_data = 8'h99;
        #2 reset = 1'b1;
        #1;
        chk("mrst_busy", busy, 0);
        chk("mrst_ptr", ptr, 0);
        rx_valid = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("mrst_idle", busy, 0);
        rd_at(7'h10, d, v); chk("mrst_m10", d, 8'h00); chk("mrst_v", v, 1);
        rd_at(7'h40, d, v); chk("mrst_m40", d, 8'h00);
        rd_at(7'h7F, d, v); chk("mrst_m7f", d, 8'h00);
        rd_at(7'h05, d, v); chk("mrst_m05", d, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
